// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 32;
    localparam int unsigned SEL_W = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request scanning from Ptr upward, modulo N_REQ.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] Req,
    input  logic [SEL_W-1:0] Ptr,
    output logic             Found,
    output logic [SEL_W-1:0] Idx
);

    logic [SEL_W-1:0] w_j;

    // Scan from the far end back toward Ptr so the closest request wins last.
    always_comb begin
        Found = 1'b0;
        Idx   = '0;
        w_j   = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            w_j = Ptr + SEL_W'(k);
            if (Req[w_j]) begin
                Found = 1'b1;
                Idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 32:1 mux select/enable with hold-limit release.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             ArbEnable,
    input  logic [N_REQ-1:0] Req,
    output logic [N_REQ-1:0] Grant,
    output logic [SEL_W-1:0] Sel,
    output logic             MuxEnable,
    output logic             Busy,
    output logic             Timeout
);

    state_t           r_state, w_state;
    logic [N_REQ-1:0] r_grant, w_grant;
    logic [SEL_W-1:0] r_sel, w_sel;
    logic             r_mux_en, w_mux_en;
    logic             r_timeout, w_timeout;
    logic [SEL_W-1:0] r_ptr, w_ptr;
    logic [CNT_W-1:0] r_cnt, w_cnt;

    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic             w_forced;
    logic             w_release;

    rr_pick u_pick (
        .Req   (Req),
        .Ptr   (r_ptr),
        .Found (w_found),
        .Idx   (w_idx)
    );

    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_sel     = r_sel;
        w_mux_en  = r_mux_en;
        w_timeout = 1'b0;
        w_ptr     = r_ptr;
        w_cnt     = r_cnt;
        w_forced  = 1'b0;
        w_release = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (ArbEnable && w_found) begin
                    w_state  = ST_GRANT;
                    w_grant  = N_REQ'(1) << w_idx;
                    w_sel    = w_idx;
                    w_mux_en = 1'b1;
                    w_ptr    = w_idx + SEL_W'(1);
                    w_cnt    = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                w_forced  = (MAX_HOLD != 0) && Req[r_sel] && (r_cnt == CNT_W'(MAX_HOLD));
                w_release = !Req[r_sel] || w_forced;
                if (!w_release) begin
                    if (r_cnt != '1) w_cnt = r_cnt + CNT_W'(1);
                end else begin
                    w_timeout = w_forced;
                    // Pointer already sits past the owner, so the rescan rotates priority.
                    if (ArbEnable && w_found) begin
                        w_grant  = N_REQ'(1) << w_idx;
                        w_sel    = w_idx;
                        w_mux_en = 1'b1;
                        w_ptr    = w_idx + SEL_W'(1);
                        w_cnt    = CNT_W'(1);
                    end else begin
                        w_state  = ST_IDLE;
                        w_grant  = '0;
                        w_sel    = '0;
                        w_mux_en = 1'b0;
                        w_cnt    = '0;
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_sel     <= '0;
            r_mux_en  <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_grant   <= w_grant;
            r_sel     <= w_sel;
            r_mux_en  <= w_mux_en;
            r_timeout <= w_timeout;
            r_ptr     <= w_ptr;
            r_cnt     <= w_cnt;
        end
    end

    assign Grant     = r_grant;
    assign Sel       = r_sel;
    assign MuxEnable = r_mux_en;
    assign Busy      = r_mux_en;
    assign Timeout   = r_timeout;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: default hold limit plus a MAX_HOLD=4 instance.
module tb_rr_mux_arbiter;

    logic        Clock;
    logic        Reset_n;
    logic        ArbEnable;
    logic [31:0] Req;

    logic [31:0] Grant;
    logic [4:0]  Sel;
    logic        MuxEnable, Busy, Timeout;

    logic [31:0] g4_grant;
    logic [4:0]  g4_sel;
    logic        g4_mux, g4_busy, g4_timeout;

    int total;
    int bad;

    rr_mux_arbiter dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .ArbEnable (ArbEnable),
        .Req       (Req),
        .Grant     (Grant),
        .Sel       (Sel),
        .MuxEnable (MuxEnable),
        .Busy      (Busy),
        .Timeout   (Timeout)
    );

    rr_mux_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .ArbEnable (ArbEnable),
        .Req       (Req),
        .Grant     (g4_grant),
        .Sel       (g4_sel),
        .MuxEnable (g4_mux),
        .Busy      (g4_busy),
        .Timeout   (g4_timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset_n   = 1'b0;
        ArbEnable = 1'b0;
        Req       = '0;
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (Grant !== 32'h0) begin bad++; $display("FAIL reset_grant: got %h want %h", Grant, 32'h0); end
        total++; if (Sel !== 5'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", Sel); end
        total++; if (MuxEnable !== 1'b0) begin bad++; $display("FAIL reset_muxen: got %b want 0", MuxEnable); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        total++; if (Timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", Timeout); end
        total++; if (g4_grant !== 32'h0 || g4_busy !== 1'b0) begin bad++; $display("FAIL reset_dut4: got %h/%b want 0/0", g4_grant, g4_busy); end
    endtask

    task automatic test_single();
        do_reset();
        ArbEnable = 1'b1;
        Req = 32'h0000_0001;
        tick();
        total++; if (Grant !== 32'h1) begin bad++; $display("FAIL single_grant: got %h want %h", Grant, 32'h1); end
        total++; if (Sel !== 5'd0) begin bad++; $display("FAIL single_sel: got %0d want 0", Sel); end
        total++; if (MuxEnable !== 1'b1 || Busy !== 1'b1) begin bad++; $display("FAIL single_en: got %b/%b want 1/1", MuxEnable, Busy); end
        Req = 32'h0;
        tick();
        total++; if (Grant !== 32'h0 || MuxEnable !== 1'b0) begin bad++; $display("FAIL single_release: got %h/%b want 0/0", Grant, MuxEnable); end
        // Pointer now 1: requester 1 outranks requester 0
        Req = 32'h0000_0003;
        tick();
        total++; if (Sel !== 5'd1 || Grant !== 32'h2) begin bad++; $display("FAIL single_ptr: got sel %0d grant %h want 1/%h", Sel, Grant, 32'h2); end
        Req = 32'h0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_sel;
        logic [31:0] exp_grant;
        do_reset();
        ArbEnable = 1'b1;
        Req = 32'hFFFF_FFFF;
        tick();
        total++; if (Sel !== 5'd0 || Grant !== 32'h1) begin bad++; $display("FAIL b2b_first: got sel %0d grant %h want 0/%h", Sel, Grant, 32'h1); end
        for (int i = 0; i < 32; i++) begin
            tick();
            tick();
            total++; if (Sel !== 5'(i) || MuxEnable !== 1'b1) begin bad++; $display("FAIL b2b_hold%0d: got sel %0d en %b want %0d/1", i, Sel, MuxEnable, i); end
            Req = ~(32'h1 << i);
            tick();
            Req = 32'hFFFF_FFFF;
            exp_sel   = 5'((i + 1) % 32);
            exp_grant = 32'h1 << exp_sel;
            total++; if (Sel !== exp_sel || Grant !== exp_grant || MuxEnable !== 1'b1) begin
                bad++; $display("FAIL b2b_handover%0d: got sel %0d grant %h en %b want %0d/%h/1", i, Sel, Grant, MuxEnable, exp_sel, exp_grant);
            end
            total++; if (g4_timeout !== 1'b0 || g4_sel !== exp_sel) begin bad++; $display("FAIL b2b_dut4_%0d: got sel %0d to %b want %0d/0", i, g4_sel, g4_timeout, exp_sel); end
        end
        Req = 32'h0;
        tick();
    endtask

    task automatic test_timeout();
        logic [4:0] e4_sel, e_sel;
        logic       e4_to, e_to;
        do_reset();
        ArbEnable = 1'b1;
        Req = 32'h8000_0001;
        for (int t = 1; t <= 18; t++) begin
            tick();
            e4_sel = (((t - 1) / 4) % 2 == 1) ? 5'd31 : 5'd0;
            e4_to  = (t > 1) && ((t - 1) % 4 == 0);
            e_sel  = (t <= 16) ? 5'd0 : 5'd31;
            e_to   = (t == 17);
            total++; if (g4_sel !== e4_sel || g4_timeout !== e4_to) begin
                bad++; $display("FAIL to4_t%0d: got sel %0d to %b want %0d/%b", t, g4_sel, g4_timeout, e4_sel, e4_to);
            end
            total++; if (Sel !== e_sel || Timeout !== e_to) begin
                bad++; $display("FAIL to16_t%0d: got sel %0d to %b want %0d/%b", t, Sel, Timeout, e_sel, e_to);
            end
        end
        // Lone requester hitting the limit is re-granted without a bubble
        do_reset();
        ArbEnable = 1'b1;
        Req = 32'h0000_0001;
        for (int t = 1; t <= 5; t++) tick();
        total++; if (g4_timeout !== 1'b1 || g4_grant !== 32'h1 || g4_mux !== 1'b1) begin
            bad++; $display("FAIL to_self: got to %b grant %h en %b want 1/%h/1", g4_timeout, g4_grant, g4_mux, 32'h1);
        end
        tick();
        total++; if (g4_timeout !== 1'b0 || g4_sel !== 5'd0) begin bad++; $display("FAIL to_pulse: got to %b sel %0d want 0/0", g4_timeout, g4_sel); end
        Req = 32'h0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        ArbEnable = 1'b1;
        Req = 32'h1 << 29;
        tick();
        total++; if (Sel !== 5'd29) begin bad++; $display("FAIL wrap_seed: got %0d want 29", Sel); end
        Req = 32'h0;
        tick();
        total++; if (Grant !== 32'h0) begin bad++; $display("FAIL wrap_idle: got %h want 0", Grant); end
        Req = 32'h0000_0006;
        tick();
        total++; if (Sel !== 5'd1 || Grant !== 32'h2) begin bad++; $display("FAIL wrap_first: got sel %0d grant %h want 1/%h", Sel, Grant, 32'h2); end
        Req = 32'h0000_0004;
        tick();
        total++; if (Sel !== 5'd2 || Grant !== 32'h4) begin bad++; $display("FAIL wrap_second: got sel %0d grant %h want 2/%h", Sel, Grant, 32'h4); end
        Req = 32'h0;
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        ArbEnable = 1'b0;
        Req = 32'h10;
        tick();
        tick();
        total++; if (Grant !== 32'h0 || MuxEnable !== 1'b0) begin bad++; $display("FAIL en_blocked: got %h/%b want 0/0", Grant, MuxEnable); end
        ArbEnable = 1'b1;
        tick();
        total++; if (Grant !== 32'h10 || Sel !== 5'd4) begin bad++; $display("FAIL en_grant: got %h sel %0d want %h/4", Grant, Sel, 32'h10); end
        ArbEnable = 1'b0;
        Req = 32'h30;
        tick();
        total++; if (Grant !== 32'h10 || MuxEnable !== 1'b1) begin bad++; $display("FAIL en_keep: got %h/%b want %h/1", Grant, MuxEnable, 32'h10); end
        Req = 32'h20;
        tick();
        total++; if (Grant !== 32'h0 || Sel !== 5'd0 || MuxEnable !== 1'b0) begin bad++; $display("FAIL en_nohandover: got %h sel %0d en %b want 0/0/0", Grant, Sel, MuxEnable); end
        tick();
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL en_idle: got %b want 0", Busy); end
        Req = 32'h0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ArbEnable = 1'b1;
        Req = 32'h1 << 7;
        tick();
        total++; if (Sel !== 5'd7) begin bad++; $display("FAIL rmid_seed: got %0d want 7", Sel); end
        Reset_n = 1'b0;
        tick();
        total++; if (Grant !== 32'h0 || Sel !== 5'd0 || MuxEnable !== 1'b0 || Busy !== 1'b0 || Timeout !== 1'b0) begin
            bad++; $display("FAIL rmid_clear: got %h sel %0d en %b busy %b to %b want all 0", Grant, Sel, MuxEnable, Busy, Timeout);
        end
        Reset_n = 1'b1;
        Req = 32'hFFFF_FFFF;
        tick();
        total++; if (Sel !== 5'd0 || Grant !== 32'h1) begin bad++; $display("FAIL rmid_ptr: got sel %0d grant %h want 0/%h", Sel, Grant, 32'h1); end
        Req = 32'h0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset_n   = 1'b0;
        ArbEnable = 1'b0;
        Req       = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_wrap();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
